// File: rtl/vga_sync_blink.sv
// vga_sync_blink: 640x480@60 VGA timing from a divided pixel enable, with frame pulse and cursor blink.
module vga_sync_blink #(
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CLK_DIV      = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic       parpadeo
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] blink_cnt;
    logic [9:0] x_next, y_next;
    logic x_wrap, frame_wrap, blink_last;

    always_comb begin
        x_wrap = pixel_x == H_MAX;
        frame_wrap = x_wrap && pixel_y == V_MAX;
        blink_last = blink_cnt == BLINK_MAX;
        x_next = x_wrap ? 10'd0 : pixel_x + 10'd1;
        y_next = frame_wrap ? 10'd0 : x_wrap ? pixel_y + 10'd1 : pixel_y;
    end

    assign video_on = pixel_x < H_VIS && pixel_y < V_VIS;

    // Sync levels are computed from the next coordinates so they track the displayed pixel exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            p_tick     <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
            blink_cnt  <= '0;
            parpadeo   <= 1'b0;
        end else begin
            div_cnt    <= div_cnt == DIV_MAX ? '0 : div_cnt + DW'(1);
            p_tick     <= div_cnt == DIV_MAX;
            frame_tick <= p_tick && frame_wrap;
            if (p_tick) begin
                pixel_x <= x_next;
                pixel_y <= y_next;
                hsync   <= !(x_next >= HS_START && x_next <= HS_END);
                vsync   <= !(y_next >= VS_START && y_next <= VS_END);
                if (frame_wrap) begin
                    blink_cnt <= blink_last ? '0 : blink_cnt + BW'(1);
                    if (blink_last) parpadeo <= !parpadeo;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_blink.sv
// tb_vga_sync_blink: random reset pulses on a shrunken raster, checked every cycle against an arithmetic timing model.
module tb_vga_sync_blink;
    localparam int HD = 10, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int CD = 4, BF = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0, reset = 1'b1;
    logic p_tick, video_on, hsync, vsync, frame_tick, parpadeo;
    logic [9:0] pixel_x, pixel_y;
    int checks = 0, errors = 0, k = 0, ft_seen = 0, ft_want = 0;
    bit armed = 1'b0;

    vga_sync_blink #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(CD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick), .parpadeo(parpadeo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d after reset", tag, got, want, k);
        end
    endtask

    // k counts clk edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        k <= reset ? 0 : k + 1;
        if (reset) armed <= 1'b1;
    end

    always @(negedge clk) begin
        int a, pos, x, y, fr;
        bit ft;
        if (armed) begin
            a = k > 0 ? (k - 1) / CD : 0;
            pos = a % FRAME;
            x = pos % HT;
            y = pos / HT;
            fr = a / FRAME;
            ft = a > 0 && pos == 0 && (k - 1) % CD == 0;
            ft_want += int'(ft);
            ft_seen += int'(frame_tick);
            chk("p_tick", p_tick, int'(k > 0 && k % CD == 0));
            chk("pixel_x", pixel_x, x);
            chk("pixel_y", pixel_y, y);
            chk("video_on", video_on, int'(x < HD && y < VD));
            chk("hsync", hsync, int'(!(x >= HD + HF && x < HD + HF + HS)));
            chk("vsync", vsync, int'(!(y >= VD + VF && y < VD + VF + VS)));
            chk("frame_tick", frame_tick, int'(ft));
            chk("parpadeo", parpadeo, (fr / BF) % 2);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10 * FRAME * CD + 50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b0;
            repeat ($urandom_range(1, 2 * FRAME * CD)) @(negedge clk);
        end
        repeat (3 * BF * FRAME * CD) @(negedge clk);
        chk("frame_tick_count", ft_seen, ft_want);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_blink.md
# vga_sync_blink

Timing front end of the RTC display path. Derives a 25 MHz pixel enable from the 100 MHz board clock and produces 640x480@60 Hz VGA sync with the current pixel coordinates. These coordinates drive the character generator, the box/overlay logic and the final RGB register. The block also produces a frame pulse and a frame-locked cursor blink signal (`parpadeo`) for the character generator's configuration cursor.

## Interface
- `H_DISPLAY`, 640, visible columns
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, clk cycles per pixel; must be ≥2
- `BLINK_FRAMES`, 30, frames per blink half-period; must be ≥1

Ports:
- `clk` in 1: 100 MHz system clock; the only clock in the block
- `reset` in 1: synchronous, active-high reset
- `p_tick` out 1: pixel enable, one clk cycle wide
- `pixel_x` out 10: current column, 0..H_TOTAL-1
- `pixel_y` out 10: current line, 0..V_TOTAL-1
- `video_on` out 1: high while the current pixel is in the visible area
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `frame_tick` out 1: one-cycle pulse at the start of each frame
- `parpadeo` out 1: cursor blink level

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Divider:
  - 2-bit mod-CLK_DIV counter `div_cnt`, free-running.
  - `p_tick` is registered; it is high in the clk cycle after `div_cnt` reaches CLK_DIV-1.
  - Default result: one pulse every 4 clk cycles.
- Horizontal counter `pixel_x`:
  - Advances only on `p_tick`.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter `pixel_y`:
  - Advances only on a `p_tick` cycle in which `pixel_x` == H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0.
- `video_on` = (`pixel_x` < H_DISPLAY) && (`pixel_y` < V_DISPLAY), decoded combinationally from the registered counters.
- `hsync`:
  - Registered; updated together with the counters, so it always corresponds to the displayed `pixel_x`.
  - Low when `pixel_x` ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- `vsync`:
  - Registered in the same way as `hsync`.
  - Low when `pixel_y` ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- `frame_tick`:
  - Registered; high for exactly one clk cycle.
  - That cycle is the first cycle in which the counters read (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1).
- Blink:
  - Frame counter `blink_cnt`, 0..BLINK_FRAMES-1, increments on each frame wrap.
  - On a wrap with `blink_cnt` == BLINK_FRAMES-1: `blink_cnt` clears to 0 and `parpadeo` toggles.
  - The toggle becomes visible in the same cycle as `frame_tick`.
  - Default blink period is 60 frames, about 1 s with a 50 % duty cycle.
- Reset values:
  - `div_cnt`=0, `p_tick`=0, `pixel_x`=0, `pixel_y`=0, `blink_cnt`=0.
  - `hsync`=1, `vsync`=1, `frame_tick`=0, `parpadeo`=0.
  - `video_on` is therefore 1 during and immediately after reset, because (0,0) is a visible pixel.
- Reset asserted mid-frame forces all state above to its reset value at the next clk edge, regardless of `p_tick`. The frame then restarts at (0,0) with no `frame_tick` for the aborted frame.
- Simultaneous wraps: at (H_TOTAL-1, V_TOTAL-1) with `p_tick`, both counters go to 0 in the same cycle. `pixel_y` must never take the value V_TOTAL.

## Timing
- One `p_tick` every CLK_DIV clk cycles. The first `p_tick` after reset release occurs on the CLK_DIV-th cycle.
- `pixel_x`, `pixel_y`, `hsync`, `vsync` and `frame_tick` change only in the clk cycle immediately after a `p_tick` cycle. They hold for CLK_DIV cycles.
- `video_on` follows the counters with zero added latency.
- Downstream consumers (character generator ROM, RGB register) see a stable coordinate for CLK_DIV-1 cycles before the next change. The one-cycle font ROM latency therefore fits inside a pixel.
- Line period = 800 `p_tick` = 3200 clk. Frame period = 420 000 `p_tick` = 1 680 000 clk.
- `parpadeo` toggles every BLINK_FRAMES × 1 680 000 clk (default 50 400 000).

## Test plan
- Reset for 3 cycles, then release: all outputs hold the reset values, `video_on`=1; the first `p_tick` arrives exactly 4 clk cycles after release; `pixel_x`=1 on the following cycle.
- Run one full line: `hsync` goes low at `pixel_x`=656 and high at 752; `video_on` falls at `pixel_x`=640; `pixel_y` increments from 0 to 1 when `pixel_x` wraps 799→0.
- Run a full frame: `vsync` is low for lines 490 and 491 only; `video_on` stays 0 for `pixel_y` ≥ 480; the counters wrap (799,524)→(0,0) with `frame_tick` high for exactly 1 clk; frame length = 1 680 000 clk.
- With BLINK_FRAMES=2 override: `parpadeo` toggles on the 2nd, 4th and 6th `frame_tick`, and no other time.
- Assert reset for 1 cycle at (`pixel_x`=300, `pixel_y`=200): the next cycle reads (0,0), `hsync`=`vsync`=1, `blink_cnt` cleared; `frame_tick` never fires for the aborted frame.
- Long run of 10 frames: `pixel_x` never exceeds 799, `pixel_y` never exceeds 524, and there is exactly one `p_tick` per 4 clk cycles throughout.
